// File: rtl/irq_exc_controller_pkg.sv
// Shared definitions for the interrupt/exception controller:
// FSM encodings, register offsets, CAUSE layout, default vectors.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TAKEN  = 2'd1,
        ST_KERNEL = 2'd2
    } fsm_state_t;

    localparam logic [1:0] REG_MASK   = 2'd0;
    localparam logic [1:0] REG_PEND   = 2'd1;
    localparam logic [1:0] REG_CAUSE  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CAUSE_EXC_BIT   = 31;
    localparam int CAUSE_VLD_BIT   = 30;
    localparam int STATUS_KERR_BIT = 8;

    // TAKEN waits this many extra clocks for kernel entry
    localparam logic [1:0] TMO_LAST = 2'd3;

    localparam logic [31:0] IRQ_VEC_DEF = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF = 32'h8000_0008;

    function automatic logic [31:0] make_cause(
        input logic       exc,
        input logic [2:0] idx
    );
        logic [31:0] c;
        c                = '0;
        c[CAUSE_EXC_BIT] = exc;
        c[CAUSE_VLD_BIT] = 1'b1;
        c[2:0]           = idx;
        return c;
    endfunction

endpackage

// File: rtl/irq_exc_controller_if.sv
// Peripheral-bus config/status port of the trap controller.
// The bus side drives strobes; the controller returns read data.
interface irq_exc_controller_if;
    logic        cfg_wr;
    logic        cfg_rd;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;

    modport master (
        output cfg_wr,
        output cfg_rd,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_rdata
    );

    modport slave (
        input  cfg_wr,
        input  cfg_rd,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_rdata
    );
endinterface

// File: rtl/irq_exc_controller_prio_enc.sv
// Lowest-index-first priority encoder: request vector -> any, index.
// Used once per trap class.
module irq_prio_enc #(
    parameter int W = 2
) (
    input  logic [W-1:0] req,
    output logic         any,
    output logic [2:0]   idx
);

    // scan high to low so the lowest set index is left in idx
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/irq_exc_controller.sv
// Trap controller: latches irq edges, masks and prioritises them
// against exceptions, and sequences one trap at a time.
import irq_pkg::*;

module irq_exc_controller #(
    parameter int          NUM_IRQ = 2,
    parameter int          NUM_EXC = 2,
    parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [NUM_EXC-1:0] exc_src,
    input  logic               kernel_mode,
    input  logic               hold_off,
    output logic               take_irq,
    output logic               take_exc,
    output logic [31:0]        vector,
    irq_exc_controller_if.slave cfg
);

    fsm_state_t         state;
    logic [1:0]         tmo_cnt;
    logic [NUM_IRQ-1:0] irq_hist;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [31:0]        cause_q;
    logic               kerr;
    logic               exc_hist;

    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] irq_vec;
    logic               irq_req;
    logic               exc_req;
    logic [2:0]         irq_idx;
    logic [2:0]         exc_idx;
    logic               exc_rise;
    logic               tmo_hit;
    logic               wr_mask;
    logic               wr_pend;
    logic               wr_status;
    logic               unused_ok;

    assign unused_ok = ^{cfg.cfg_addr[1:0], cfg.cfg_wdata};

    // decode config writes and request conditioning
    always_comb begin
        wr_mask   = 1'b0;
        wr_pend   = 1'b0;
        wr_status = 1'b0;
        if (cfg.cfg_wr) begin
            unique case (cfg.cfg_addr[3:2])
                REG_MASK:   wr_mask   = 1'b1;
                REG_PEND:   wr_pend   = 1'b1;
                REG_STATUS: wr_status = 1'b1;
                default:    ;
            endcase
        end
        irq_rise = irq_src & ~irq_hist;
        pend_clr = wr_pend ? cfg.cfg_wdata[NUM_IRQ-1:0] : '0;
        // a fresh edge counts as pending in the cycle it is latched
        irq_vec  = (pend_q | irq_rise) & mask_q;
        exc_rise = (|exc_src) & ~exc_hist;
        tmo_hit  = (state == ST_TAKEN) && !kernel_mode
                   && (tmo_cnt == TMO_LAST);
    end

    irq_prio_enc #(.W(NUM_IRQ)) u_irq_enc (
        .req (irq_vec),
        .any (irq_req),
        .idx (irq_idx)
    );

    irq_prio_enc #(.W(NUM_EXC)) u_exc_enc (
        .req (exc_src),
        .any (exc_req),
        .idx (exc_idx)
    );

    // source history, pending latch (set beats W1C) and mask
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_hist <= '0;
            exc_hist <= 1'b0;
            pend_q   <= '0;
            mask_q   <= '0;
        end else begin
            irq_hist <= irq_src;
            exc_hist <= |exc_src;
            pend_q   <= (pend_q & ~pend_clr) | irq_rise;
            if (wr_mask) mask_q <= cfg.cfg_wdata[NUM_IRQ-1:0];
        end
    end

    // sticky kernel error: missed kernel entry or exception in kernel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kerr <= 1'b0;
        end else if (tmo_hit || (exc_rise && kernel_mode)) begin
            kerr <= 1'b1;
        end else if (wr_status && cfg.cfg_wdata[STATUS_KERR_BIT]) begin
            kerr <= 1'b0;
        end
    end

    // trap sequencer with registered take pulses, vector and cause
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            tmo_cnt  <= '0;
            take_irq <= 1'b0;
            take_exc <= 1'b0;
            vector   <= '0;
            cause_q  <= '0;
        end else begin
            take_irq <= 1'b0;
            take_exc <= 1'b0;
            vector   <= '0;
            unique case (state)
                ST_IDLE: begin
                    if ((exc_req || irq_req) && !kernel_mode && !hold_off) begin
                        state   <= ST_TAKEN;
                        tmo_cnt <= '0;
                        if (exc_req) begin
                            take_exc <= 1'b1;
                            vector   <= EXC_VEC;
                            cause_q  <= make_cause(1'b1, exc_idx);
                        end else begin
                            take_irq <= 1'b1;
                            vector   <= IRQ_VEC;
                            cause_q  <= make_cause(1'b0, irq_idx);
                        end
                    end
                end
                ST_TAKEN: begin
                    if (kernel_mode) begin
                        state <= ST_KERNEL;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 2'd1;
                    end
                end
                ST_KERNEL: begin
                    if (!kernel_mode) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // combinational register read, zero when not selected
    always_comb begin
        cfg.cfg_rdata = '0;
        if (cfg.cfg_rd) begin
            unique case (cfg.cfg_addr[3:2])
                REG_MASK:   cfg.cfg_rdata = 32'(mask_q);
                REG_PEND:   cfg.cfg_rdata = 32'(pend_q);
                REG_CAUSE:  cfg.cfg_rdata = cause_q;
                REG_STATUS: cfg.cfg_rdata = {23'd0, kerr, 6'd0, state};
                default:    cfg.cfg_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_exc_controller.sv
// Directed bench for irq_exc_controller: take latency, priority,
// hold-off, kernel nesting, timeout, W1C race and async reset.
module tb_irq_exc_controller;
    import irq_pkg::*;

    logic       clk;
    logic       reset;
    logic [1:0] irq_src;
    logic [1:0] exc_src;
    logic       kernel_mode;
    logic       hold_off;
    logic       take_irq;
    logic       take_exc;
    logic [31:0] vector;

    int n_cmp;
    int n_bad;

    irq_exc_controller_if bus ();

    irq_exc_controller dut (
        .clk         (clk),
        .reset       (reset),
        .irq_src     (irq_src),
        .exc_src     (exc_src),
        .kernel_mode (kernel_mode),
        .hold_off    (hold_off),
        .take_irq    (take_irq),
        .take_exc    (take_exc),
        .vector      (vector),
        .cfg         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] d);
        bus.cfg_rd   = 1'b1;
        bus.cfg_addr = {r, 2'b00};
        #1;
        d = bus.cfg_rdata;
        bus.cfg_rd = 1'b0;
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d);
        bus.cfg_wr    = 1'b1;
        bus.cfg_addr  = {r, 2'b00};
        bus.cfg_wdata = d;
        tick();
        bus.cfg_wr    = 1'b0;
        bus.cfg_wdata = '0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] r,
                           input logic [31:0] exp);
        logic [31:0] d;
        rd(r, d);
        chk(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        n_cmp         = 0;
        n_bad         = 0;
        reset         = 1'b0;
        irq_src       = '0;
        exc_src       = '0;
        kernel_mode   = 1'b0;
        hold_off      = 1'b0;
        bus.cfg_wr    = 1'b0;
        bus.cfg_rd    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        tick();
        tick();

        chk("rst_take_irq", 32'(take_irq), 32'd0);
        chk("rst_take_exc", 32'(take_exc), 32'd0);
        chk("rst_vector", vector, 32'd0);
        chk_reg("rst_mask", REG_MASK, 32'd0);
        chk_reg("rst_pend", REG_PEND, 32'd0);
        chk_reg("rst_cause", REG_CAUSE, 32'd0);
        chk_reg("rst_status", REG_STATUS, 32'd0);
        reset = 1'b1;
        tick();

        // timer pulse
        wr(REG_MASK, 32'h1);
        irq_src = 2'b01;
        tick();
        chk("t1_take_irq", 32'(take_irq), 32'd1);
        chk("t1_take_exc", 32'(take_exc), 32'd0);
        chk("t1_vector", vector, 32'h8000_0004);
        chk_reg("t1_cause", REG_CAUSE, 32'h4000_0000);
        chk_reg("t1_pend", REG_PEND, 32'h1);
        chk_reg("t1_status", REG_STATUS, 32'h1);
        kernel_mode = 1'b1;
        tick();
        chk("t1_pulse_drop", 32'(take_irq), 32'd0);
        chk("t1_vec_drop", vector, 32'd0);
        chk_reg("t1_kernel", REG_STATUS, 32'h2);
        irq_src = 2'b00;
        wr(REG_PEND, 32'h1);
        kernel_mode = 1'b0;
        tick();
        chk_reg("t1_idle", REG_STATUS, 32'h0);
        chk_reg("t1_w1c", REG_PEND, 32'h0);

        // exception beats interrupt
        irq_src = 2'b01;
        exc_src = 2'b10;
        tick();
        chk("t2_take_exc", 32'(take_exc), 32'd1);
        chk("t2_take_irq", 32'(take_irq), 32'd0);
        chk("t2_vector", vector, 32'h8000_0008);
        chk_reg("t2_cause", REG_CAUSE, 32'hC000_0001);
        kernel_mode = 1'b1;
        tick();
        chk_reg("t2_kernel", REG_STATUS, 32'h2);
        exc_src = 2'b00;
        irq_src = 2'b00;
        wr(REG_PEND, 32'h1);
        kernel_mode = 1'b0;
        tick();
        chk_reg("t2_idle", REG_STATUS, 32'h0);

        // hold_off defers the take
        hold_off = 1'b1;
        irq_src  = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t3_hold%0d", i), 32'(take_irq), 32'd0);
        end
        hold_off = 1'b0;
        tick();
        chk("t3_take", 32'(take_irq), 32'd1);

        // irq arriving in kernel waits for return
        kernel_mode = 1'b1;
        tick();
        wr(REG_PEND, 32'h1);
        wr(REG_MASK, 32'h3);
        irq_src = 2'b11;
        tick();
        chk("t4_nest0", 32'(take_irq), 32'd0);
        chk_reg("t4_pend", REG_PEND, 32'h2);
        tick();
        chk("t4_nest1", 32'(take_irq), 32'd0);
        kernel_mode = 1'b0;
        tick();
        chk_reg("t4_idle", REG_STATUS, 32'h0);
        tick();
        chk("t4_take", 32'(take_irq), 32'd1);
        chk_reg("t4_cause", REG_CAUSE, 32'h4000_0001);

        // kernel entry timeout
        wr(REG_PEND, 32'h2);
        tick();
        tick();
        chk_reg("t5_wait", REG_STATUS, 32'h1);
        tick();
        chk_reg("t5_kerr", REG_STATUS, 32'h100);
        chk("t5_no_take", 32'({take_irq, take_exc}), 32'd0);
        wr(REG_STATUS, 32'h100);
        chk_reg("t5_kerr_clr", REG_STATUS, 32'h0);

        // W1C loses to a same-cycle edge
        irq_src = 2'b00;
        tick();
        irq_src = 2'b01;
        wr(REG_PEND, 32'h1);
        chk_reg("t6_pend", REG_PEND, 32'h1);
        chk("t6_take", 32'(take_irq), 32'd1);

        // asynchronous reset in TAKEN
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_take", 32'(take_irq), 32'd0);
        chk("t6_rst_vec", vector, 32'd0);
        chk_reg("t6_rst_status", REG_STATUS, 32'h0);
        chk_reg("t6_rst_pend", REG_PEND, 32'h0);
        irq_src = 2'b00;
        tick();
        reset = 1'b1;
        tick();

        // exception in kernel mode: kerr, no take
        kernel_mode = 1'b1;
        exc_src     = 2'b01;
        tick();
        chk("t7_no_exc", 32'(take_exc), 32'd0);
        chk_reg("t7_kerr", REG_STATUS, 32'h100);
        bus.cfg_rd   = 1'b0;
        bus.cfg_addr = {REG_STATUS, 2'b00};
        #1;
        chk("t7_rd_idle", bus.cfg_rdata, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
